// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizes for the MEM-stage data-memory controller.
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts REQ cycles; expired_o flags the cycle in which the count reaches
// TIMEOUT so the controller can give up on a silent memory.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // this increment takes the count to TIMEOUT
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: turns a load/store into a
// req/ack handshake and stalls the pipeline until the access finishes.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    state_t state_q;
    state_t state_d;
    logic   we_q;
    logic   access;
    logic   in_req;
    logic   cnt_clr;
    logic   expired;

    assign access  = MemRead_i | MemWrite_i;
    assign in_req  = (state_q == ST_REQ);
    assign cnt_clr = !in_req || mem_ack_i;

    mem_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (cnt_clr),
        .en_i     (in_req),
        .expired_o(expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stall in IDLE is combinational so EX/MEM holds the new request
    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        mem_req_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                stall_o = access;
                if (access) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                if (mem_ack_i || expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            we_q        <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && access) begin
                mem_addr_o  <= addr_i;
                mem_wdata_o <= wdata_i;
                we_q        <= MemWrite_i;
            end
            if (in_req && mem_ack_i && !we_q) begin
                rdata_o <= mem_rdata_i;
            end
            // an ack in the expiry cycle still counts as success
            if (in_req && !mem_ack_i && expired) begin
                err_o <= 1'b1;
            end
        end
    end

    assign mem_we_o = we_q;

endmodule
